// File: rtl/edc_pkg.sv
// Shared definitions for the (39,32) Hamming SECDED encoder and checker.
package edc_pkg;

    localparam int DATA_W  = 32;
    localparam int CHECK_W = 7;
    localparam int CODE_W  = 39;

    // Code position (1..38) of each data bit; powers of two are left for c0..c5.
    localparam logic [5:0] DATA_POS [DATA_W] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    // Outcome of decoding one received word.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        SEC  = 2'd1,
        DED  = 2'd2
    } dec_class_t;

    // Check bits c0..c5 cover the positions whose index has that bit set;
    // c6 makes the parity of all 39 bits even.
    function automatic logic [CHECK_W-1:0] edc_gen(input logic [DATA_W-1:0] data);
        logic [CHECK_W-1:0] c;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < DATA_W; k++) begin
                if (DATA_POS[k][i]) begin
                    c[i] = c[i] ^ data[k];
                end
            end
        end
        c[6] = (^data) ^ (^c[5:0]);
        return c;
    endfunction

endpackage

// File: rtl/edcc_syn.sv
// Combinational SECDED checker: syndrome, overall parity and corrected data.
module edcc_syn
    import edc_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic [CHECK_W-1:0] check,
    output logic [5:0]         syn,
    output logic               par,
    output logic [DATA_W-1:0]  corr_data,
    output dec_class_t         dec
);

    logic [CHECK_W-1:0] calc;

    // Classify the word and flip the single data bit a correctable syndrome points at.
    always_comb begin
        calc      = edc_gen(data);
        syn       = calc[5:0] ^ check[5:0];
        par       = (^data) ^ (^check);
        corr_data = data;
        dec       = NONE;
        if (par) begin
            if (syn <= 6'd38) begin
                dec = SEC;
                for (int k = 0; k < DATA_W; k++) begin
                    if (DATA_POS[k] == syn) begin
                        corr_data[k] = ~data[k];
                    end
                end
            end else begin
                dec = DED;
            end
        end else if (syn != 6'd0) begin
            dec = DED;
        end
    end

endmodule

// File: rtl/edcc_mod.sv
// Two-stage SECDED checker with backpressure, error counters and first-error capture.
module edcc_mod
    import edc_pkg::*;
#(
    parameter int WB_DWIDTH  = 32,
    parameter int EDC_CWIDTH = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WB_DWIDTH-1:0]  i_data,
    input  logic [EDC_CWIDTH-1:0] i_check,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WB_DWIDTH-1:0]  o_data,
    output logic                  o_sec,
    output logic                  o_ded,
    input  logic                  i_clr,
    output logic [CNT_WIDTH-1:0]  o_sec_cnt,
    output logic [CNT_WIDTH-1:0]  o_ded_cnt,
    output logic                  o_err_vld,
    output logic [6:0]            o_err_syn
);

    logic                  advance;
    logic                  xfer;
    logic                  s1_valid;
    logic [WB_DWIDTH-1:0]  s1_data;
    logic [EDC_CWIDTH-1:0] s1_check;
    logic [5:0]            syn;
    logic                  par;
    logic [WB_DWIDTH-1:0]  corr_data;
    dec_class_t            dec;
    logic [6:0]            s2_syn;

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;
    assign xfer    = o_valid && i_ready;

    edcc_syn u_syn (
        .data      (s1_data),
        .check     (s1_check),
        .syn       (syn),
        .par       (par),
        .corr_data (corr_data),
        .dec       (dec)
    );

    // Both stages move together; a stalled output freezes the whole pipe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_check <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_sec    <= 1'b0;
            o_ded    <= 1'b0;
            s2_syn   <= '0;
        end else if (advance) begin
            s1_valid <= i_valid && o_ready;
            s1_data  <= i_data;
            s1_check <= i_check;
            o_valid  <= s1_valid;
            o_data   <= corr_data;
            o_sec    <= s1_valid && (dec == SEC);
            o_ded    <= s1_valid && (dec == DED);
            s2_syn   <= {par, syn};
        end
    end

    // Saturating counters of flagged beats actually handed downstream; clear beats counting.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            o_sec_cnt <= '0;
            o_ded_cnt <= '0;
        end else if (xfer) begin
            if (o_sec && (o_sec_cnt != {CNT_WIDTH{1'b1}})) begin
                o_sec_cnt <= o_sec_cnt + CNT_WIDTH'(1);
            end
            if (o_ded && (o_ded_cnt != {CNT_WIDTH{1'b1}})) begin
                o_ded_cnt <= o_ded_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Keep {parity, syndrome} of the first flagged beat until cleared.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            o_err_vld <= 1'b0;
            o_err_syn <= '0;
        end else if (xfer && (o_sec || o_ded) && !o_err_vld) begin
            o_err_vld <= 1'b1;
            o_err_syn <= s2_syn;
        end
    end

endmodule

// File: tb/tb_edcc_mod.sv
// Directed-vector bench for edcc_mod with hand-computed expectations.
module tb_edcc_mod;

    localparam int CW = 2;

    logic          i_clk;
    logic          i_reset;
    logic          i_valid;
    logic          o_ready;
    logic [31:0]   i_data;
    logic [6:0]    i_check;
    logic          o_valid;
    logic          i_ready;
    logic [31:0]   o_data;
    logic          o_sec;
    logic          o_ded;
    logic          i_clr;
    logic [CW-1:0] o_sec_cnt;
    logic [CW-1:0] o_ded_cnt;
    logic          o_err_vld;
    logic [6:0]    o_err_syn;

    int check_count = 0;
    int error_count = 0;

    edcc_mod #(.WB_DWIDTH(32), .EDC_CWIDTH(7), .CNT_WIDTH(CW)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_check   (i_check),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_sec     (o_sec),
        .o_ded     (o_ded),
        .i_clr     (i_clr),
        .o_sec_cnt (o_sec_cnt),
        .o_ded_cnt (o_ded_cnt),
        .o_err_vld (o_err_vld),
        .o_err_syn (o_err_syn)
    );

    // Free-running clock, period 10.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one beat into an idle pipe and check it appears exactly two cycles later.
    task automatic applyStimulus(input string name, input logic [31:0] d, input logic [6:0] c,
                                 input logic [31:0] exp_d, input logic exp_sec, input logic exp_ded);
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        i_check = c;
        @(negedge i_clk);
        i_valid = 1'b0;
        checkOutput({name, "_lat1_valid"}, 32'(o_valid), 32'd0);
        @(negedge i_clk);
        checkOutput({name, "_lat2_valid"}, 32'(o_valid), 32'd1);
        checkOutput({name, "_data"}, o_data, exp_d);
        checkOutput({name, "_sec"}, 32'(o_sec), 32'(exp_sec));
        checkOutput({name, "_ded"}, 32'(o_ded), 32'(exp_ded));
        @(negedge i_clk);
    endtask

    logic [31:0] sd [5];
    logic [6:0]  sc [5];

    initial begin
        int sent;
        int rcv;
        int extra;
        logic held_valid;
        logic [31:0] held_data;

        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_check = '0;
        i_ready = 1'b1;
        i_clr   = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_data", o_data, 32'd0);
        checkOutput("rst_sec_cnt", 32'(o_sec_cnt), 32'd0);
        checkOutput("rst_ded_cnt", 32'(o_ded_cnt), 32'd0);
        checkOutput("rst_err_vld", 32'(o_err_vld), 32'd0);

        // Clean word, first single error, first double error.
        applyStimulus("clean0", 32'h0, 7'h00, 32'h0, 1'b0, 1'b0);
        checkOutput("clean0_sec_cnt", 32'(o_sec_cnt), 32'd0);
        checkOutput("clean0_err_vld", 32'(o_err_vld), 32'd0);
        applyStimulus("d0flip", 32'h1, 7'h00, 32'h0, 1'b1, 1'b0);
        checkOutput("d0flip_sec_cnt", 32'(o_sec_cnt), 32'd1);
        checkOutput("d0flip_err_vld", 32'(o_err_vld), 32'd1);
        checkOutput("d0flip_err_syn", 32'(o_err_syn), 32'h43);
        applyStimulus("dbl", 32'h3, 7'h00, 32'h3, 1'b0, 1'b1);
        checkOutput("dbl_ded_cnt", 32'(o_ded_cnt), 32'd1);
        checkOutput("dbl_sec_cnt", 32'(o_sec_cnt), 32'd1);
        checkOutput("dbl_err_syn_kept", 32'(o_err_syn), 32'h43);

        // Plain clear.
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        checkOutput("clr_sec_cnt", 32'(o_sec_cnt), 32'd0);
        checkOutput("clr_ded_cnt", 32'(o_ded_cnt), 32'd0);
        checkOutput("clr_err_vld", 32'(o_err_vld), 32'd0);

        // Five correctable beats: c6, c0, d31 (position 38), d16 (position 22), d3 of a codeword.
        applyStimulus("c6flip", 32'h0, 7'h40, 32'h0, 1'b1, 1'b0);
        checkOutput("c6flip_err_syn", 32'(o_err_syn), 32'h40);
        checkOutput("c6flip_sec_cnt", 32'(o_sec_cnt), 32'd1);
        applyStimulus("c0flip", 32'h0, 7'h01, 32'h0, 1'b1, 1'b0);
        checkOutput("c0flip_sec_cnt", 32'(o_sec_cnt), 32'd2);
        applyStimulus("d31flip", 32'h8000_0000, 7'h00, 32'h0, 1'b1, 1'b0);
        checkOutput("d31flip_sec_cnt", 32'(o_sec_cnt), 32'd3);
        applyStimulus("d16flip", 32'h0001_0000, 7'h00, 32'h0, 1'b1, 1'b0);
        checkOutput("d16flip_sec_cnt_sat", 32'(o_sec_cnt), 32'd3);
        applyStimulus("cw_d3flip", 32'h9, 7'h43, 32'h1, 1'b1, 1'b0);
        checkOutput("cw_d3flip_sec_cnt_sat", 32'(o_sec_cnt), 32'd3);
        checkOutput("sec_err_syn_kept", 32'(o_err_syn), 32'h40);

        // Syndrome 39 with odd parity is beyond the code length: uncorrectable.
        applyStimulus("syn39", 32'h8000_0000, 7'h41, 32'h8000_0000, 1'b0, 1'b1);
        checkOutput("syn39_ded_cnt", 32'(o_ded_cnt), 32'd1);

        // Sixth single-error beat transfers in the same cycle as a clear.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 32'h1;
        i_check = 7'h00;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("clrx_pre_valid", 32'(o_valid), 32'd1);
        checkOutput("clrx_pre_sec", 32'(o_sec), 32'd1);
        i_clr = 1'b1;
        @(negedge i_clk);
        i_clr = 1'b0;
        checkOutput("clrx_sec_cnt", 32'(o_sec_cnt), 32'd0);
        checkOutput("clrx_ded_cnt", 32'(o_ded_cnt), 32'd0);
        checkOutput("clrx_err_vld", 32'(o_err_vld), 32'd0);

        // Stream of five clean codewords with the sink stalled for cycles 3-5.
        sd = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h8};
        sc = '{7'h00, 7'h43, 7'h45, 7'h46, 7'h07};
        sent = 0;
        rcv = 0;
        held_valid = 1'b0;
        held_data = '0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            @(negedge i_clk);
            if (held_valid) begin
                checkOutput("stall_hold_valid", 32'(o_valid), 32'd1);
                checkOutput("stall_hold_data", o_data, held_data);
            end
            i_ready = !(cyc >= 3 && cyc <= 5);
            i_valid = (sent < 5);
            i_data  = (sent < 5) ? sd[sent] : 32'h0;
            i_check = (sent < 5) ? sc[sent] : 7'h00;
            #1;
            held_valid = 1'b0;
            if (o_valid && !i_ready) begin
                checkOutput("stall_ready", 32'(o_ready), 32'd0);
                held_valid = 1'b1;
                held_data = o_data;
            end
            if (o_valid && i_ready) begin
                checkOutput("stream_data", o_data, sd[rcv]);
                checkOutput("stream_flags", {30'd0, o_sec, o_ded}, 32'd0);
                rcv++;
            end
            if (i_valid && o_ready) sent++;
        end
        checkOutput("stream_delivered", 32'(rcv), 32'd5);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_valid) extra++;
        end
        checkOutput("stream_no_dup", 32'(extra), 32'd0);

        // Reset with two beats held in the pipe.
        applyStimulus("pre_rst", 32'h1, 7'h00, 32'h0, 1'b1, 1'b0);
        checkOutput("pre_rst_sec_cnt", 32'(o_sec_cnt), 32'd1);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = 32'h1;
        i_check = 7'h43;
        @(negedge i_clk);
        i_data  = 32'h2;
        i_check = 7'h45;
        @(negedge i_clk);
        i_valid = 1'b0;
        checkOutput("inflight_valid", 32'(o_valid), 32'd1);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checkOutput("rst2_valid", 32'(o_valid), 32'd0);
        checkOutput("rst2_ready", 32'(o_ready), 32'd1);
        checkOutput("rst2_data", o_data, 32'd0);
        checkOutput("rst2_sec_cnt", 32'(o_sec_cnt), 32'd0);
        checkOutput("rst2_err_vld", 32'(o_err_vld), 32'd0);
        checkOutput("rst2_err_syn", 32'(o_err_syn), 32'd0);
        i_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_valid) extra++;
        end
        checkOutput("rst2_no_stale", 32'(extra), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
